// File: rtl/p_beid_interconnect_f0_ahb_mtx_input_hold_pkg.sv
// Shared types for the AHB matrix input stage: HTRANS/HBURST encodings,
// FSM state encoding, held address-phase bundle and region decode helpers.
package p_beid_interconnect_f0_ahb_mtx_input_hold_pkg;

    typedef enum logic [1:0] {
        TRN_IDLE   = 2'b00,
        TRN_BUSY   = 2'b01,
        TRN_NONSEQ = 2'b10,
        TRN_SEQ    = 2'b11
    } trans_t;

    typedef enum logic [2:0] {
        BUR_SINGLE = 3'd0,
        BUR_INCR   = 3'd1,
        BUR_WRAP4  = 3'd2,
        BUR_INCR4  = 3'd3,
        BUR_WRAP8  = 3'd4,
        BUR_INCR8  = 3'd5,
        BUR_WRAP16 = 3'd6,
        BUR_INCR16 = 3'd7
    } burst_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_DPHASE = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
    } aphase_t;

    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/p_beid_interconnect_f0_ahb_mtx_input_hold_if.sv
// Bus bundle of one matrix input port: master-facing AHB slave side,
// arbiter request/grant and the address phase broadcast to all outputs.
// Modport slave is taken by the input stage, master by whoever drives it.
interface p_beid_interconnect_f0_ahb_mtx_input_hold_if;

    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic [3:0]  req_port;
    logic [3:0]  gnt_port;
    logic [3:0]  HREADYM;
    logic [3:0]  HRESPM;
    logic [31:0] HADDRM;
    logic [1:0]  HTRANSM;
    logic        HWRITEM;
    logic [2:0]  HSIZEM;
    logic [2:0]  HBURSTM;
    logic [3:0]  HPROTM;
    logic        HMASTLOCKM;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES,
        input  HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        input  gnt_port, HREADYM, HRESPM,
        output HREADYOUTS, HRESPS, req_port,
        output HADDRM, HTRANSM, HWRITEM, HSIZEM,
        output HBURSTM, HPROTM, HMASTLOCKM
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES,
        output HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        output gnt_port, HREADYM, HRESPM,
        input  HREADYOUTS, HRESPS, req_port,
        input  HADDRM, HTRANSM, HWRITEM, HSIZEM,
        input  HBURSTM, HPROTM, HMASTLOCKM
    );

endinterface

// File: rtl/p_beid_interconnect_f0_ahb_mtx_decodeS.sv
// Address decoder shared by every matrix input port.
// i_addr -> o_dec (one-hot output port, lowest index wins), o_dec_err.
module p_beid_interconnect_f0_ahb_mtx_decodeS
    import p_beid_interconnect_f0_ahb_mtx_input_hold_pkg::*;
#(
    parameter logic [31:0] BASE0   = 32'h0000_0000,
    parameter logic [31:0] BASE1   = 32'h2000_0000,
    parameter logic [31:0] BASE2   = 32'h4000_0000,
    parameter logic [31:0] BASE3   = 32'h6000_0000,
    parameter logic [31:0] MASK0   = 32'hE000_0000,
    parameter logic [31:0] MASK1   = 32'hE000_0000,
    parameter logic [31:0] MASK2   = 32'hE000_0000,
    parameter logic [31:0] MASK3   = 32'hE000_0000,
    parameter logic [3:0]  CONNECT = 4'b1111
) (
    input  logic [31:0] i_addr,
    output logic [3:0]  o_dec,
    output logic        o_dec_err
);

    logic [3:0] w_hit;

    assign w_hit[0] = region_hit(i_addr, BASE0, MASK0) & CONNECT[0];
    assign w_hit[1] = region_hit(i_addr, BASE1, MASK1) & CONNECT[1];
    assign w_hit[2] = region_hit(i_addr, BASE2, MASK2) & CONNECT[2];
    assign w_hit[3] = region_hit(i_addr, BASE3, MASK3) & CONNECT[3];

    always_comb begin
        o_dec = 4'b0000;
        if (w_hit[0])      o_dec = 4'b0001;
        else if (w_hit[1]) o_dec = 4'b0010;
        else if (w_hit[2]) o_dec = 4'b0100;
        else if (w_hit[3]) o_dec = 4'b1000;
    end

    assign o_dec_err = ~|w_hit;

endmodule

// File: rtl/p_beid_interconnect_f0_ahb_mtx_input_hold.sv
// AHB matrix input stage: decodes a master transfer, requests the target
// output arbiter, holds the transfer until granted, answers unmapped
// addresses with a local two-cycle ERROR.
// Ports: HCLK, HRESET (sync, active high), bus (slave modport).
module p_beid_interconnect_f0_ahb_mtx_input_hold
    import p_beid_interconnect_f0_ahb_mtx_input_hold_pkg::*;
#(
    parameter logic [31:0] BASE0   = 32'h0000_0000,
    parameter logic [31:0] BASE1   = 32'h2000_0000,
    parameter logic [31:0] BASE2   = 32'h4000_0000,
    parameter logic [31:0] BASE3   = 32'h6000_0000,
    parameter logic [31:0] MASK0   = 32'hE000_0000,
    parameter logic [31:0] MASK1   = 32'hE000_0000,
    parameter logic [31:0] MASK2   = 32'hE000_0000,
    parameter logic [31:0] MASK3   = 32'hE000_0000,
    parameter logic [3:0]  CONNECT = 4'b1111
) (
    input logic HCLK,
    input logic HRESET,
    p_beid_interconnect_f0_ahb_mtx_input_hold_if.slave bus
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_hold_valid;
    aphase_t    r_hold;
    logic [3:0] r_hsel;
    logic [1:0] r_dsel;
    logic [1:0] w_dsel_nxt;
    logic       w_capture;

    logic       w_vld;
    logic [3:0] w_dec;
    logic       w_dec_err;
    logic [3:0] w_kvec;
    logic       w_acc;
    logic       w_rdy;
    logic       w_resp;
    aphase_t    w_live;
    aphase_t    w_out;
    logic [3:0] w_lock_req;

    p_beid_interconnect_f0_ahb_mtx_decodeS #(
        .BASE0(BASE0), .BASE1(BASE1), .BASE2(BASE2), .BASE3(BASE3),
        .MASK0(MASK0), .MASK1(MASK1), .MASK2(MASK2), .MASK3(MASK3),
        .CONNECT(CONNECT)
    ) u_dec (
        .i_addr   (bus.HADDRS),
        .o_dec    (w_dec),
        .o_dec_err(w_dec_err)
    );

    assign w_vld = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];

    assign w_live = '{
        addr:  bus.HADDRS,
        trans: bus.HTRANSS,
        write: bus.HWRITES,
        size:  bus.HSIZES,
        burst: bus.HBURSTS,
        prot:  bus.HPROTS,
        lock:  bus.HMASTLOCKS
    };

    // A held transfer owns the request lines until it is accepted.
    assign w_kvec = r_hold_valid ? r_hsel : w_dec;
    assign w_acc  = |(w_kvec & bus.gnt_port & bus.HREADYM);

    assign w_out = r_hold_valid ? r_hold : w_live;

    assign bus.HADDRM     = w_out.addr;
    assign bus.HWRITEM    = w_out.write;
    assign bus.HSIZEM     = w_out.size;
    assign bus.HBURSTM    = w_out.burst;
    assign bus.HPROTM     = w_out.prot;
    assign bus.HMASTLOCKM = w_out.lock;
    assign bus.HTRANSM    = r_hold_valid ? r_hold.trans :
                            w_vld        ? bus.HTRANSS  : TRN_IDLE;

    // Locked sequences keep the current output's arbiter parked on us.
    assign w_lock_req = (r_state == ST_DPHASE && w_out.lock) ?
                        (4'b0001 << r_dsel) : 4'b0000;

    assign bus.req_port = (r_hold_valid ? r_hsel :
                           ({4{w_vld & ~w_dec_err}} & w_dec)) | w_lock_req;

    assign bus.HREADYOUTS = w_rdy;
    assign bus.HRESPS     = w_resp;

    always_comb begin
        w_state_nxt = r_state;
        w_dsel_nxt  = r_dsel;
        w_capture   = 1'b0;
        w_rdy       = 1'b1;
        w_resp      = 1'b0;
        unique case (r_state)
            ST_HOLD: begin
                w_rdy = 1'b0;
                if (w_acc) begin
                    w_state_nxt = ST_DPHASE;
                    w_dsel_nxt  = onehot_idx(r_hsel);
                end
            end
            ST_ERR1: begin
                w_rdy       = 1'b0;
                w_resp      = 1'b1;
                w_state_nxt = ST_ERR2;
            end
            ST_IDLE, ST_DPHASE, ST_ERR2: begin
                if (r_state == ST_DPHASE) begin
                    w_rdy  = bus.HREADYM[r_dsel];
                    w_resp = bus.HRESPM[r_dsel];
                end
                if (r_state == ST_ERR2) w_resp = 1'b1;
                if (w_vld) begin
                    if (w_dec_err) begin
                        w_state_nxt = ST_ERR1;
                    end else if (w_acc) begin
                        w_state_nxt = ST_DPHASE;
                        w_dsel_nxt  = onehot_idx(w_dec);
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_capture   = 1'b1;
                    end
                end else if (r_state == ST_DPHASE &&
                             !bus.HREADYM[r_dsel]) begin
                    w_state_nxt = ST_DPHASE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= ST_IDLE;
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_hsel       <= 4'b0000;
            r_dsel       <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_dsel  <= w_dsel_nxt;
            if (w_capture) begin
                r_hold_valid <= 1'b1;
                r_hold       <= w_live;
                r_hsel       <= w_dec;
            end else if (r_state == ST_HOLD && w_acc) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/p_beid_interconnect_f0_ahb_mtx_input_hold.md
Name: p_beid_interconnect_f0_ahb_mtx_input_hold

Overview:
Slave-side input stage of the AHB bus matrix. It faces one master (or a master-side AHB-Lite port) and drives the request side of the per-output round-robin arbiters. Each incoming transfer is decoded to one of four output ports. A transfer is held in a register and the master is stalled until the target arbiter grants this port. Unmapped addresses get a two-cycle AHB ERROR response generated locally.

Parameters:
BASE0..BASE3, 32'h0000_0000/2000_0000/4000_0000/6000_0000, region base for output k
MASK0..MASK3, 32'hE000_0000 each, region compare mask; hit_k = ((HADDRS & MASKk) == BASEk)
CONNECT, 4'b1111, sparse connectivity; bit k = 0 means output k is unreachable from this port

Ports:
HCLK  in  1  AHB system clock
HRESET  in  1  synchronous active-high reset
HSELS  in  1  master-side slave select
HADDRS  in  32  address
HTRANSS  in  2  transfer type
HWRITES  in  1  write
HSIZES  in  3  size
HBURSTS  in  3  burst type
HPROTS  in  4  protection
HMASTLOCKS  in  1  locked
HREADYS  in  1  HREADY seen by the master
HREADYOUTS  out  1  ready returned to the master
HRESPS  out  1  response returned to the master (1 = ERROR)
req_port  out  4  request to output arbiter k
gnt_port  in  4  bit k = output k arbiter has addr_in_port == this port and no_port == 0
HREADYM  in  4  HREADY of output k
HRESPM  in  1x4  HRESP of output k
HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM  out  32/2/1/3/3/4/1  address-phase signals to all outputs (held or live)

Behaviour:
- Clock and reset: single clock HCLK; HRESET is synchronous active-high.
- Reset values: state = IDLE, hold_valid = 0, dsel = 0. Outputs: HREADYOUTS = 1, HRESPS = 0, req_port = 0, HTRANSM = IDLE, other held fields = 0.
- Valid live transfer: vld = HSELS & HREADYS & HTRANSS[1].
  - Decode: lowest-index k with hit_k & CONNECT[k]; no hit gives dec_err.
  - BUSY and IDLE are never held.
- Address-phase mux: hold_valid selects the held register fields; otherwise live inputs pass through.
  - HTRANSM is forced to IDLE when neither a held nor a live valid transfer exists.
- Requests:
  - req_port[k] = hold_valid ? hsel_k : (vld & dec_k & ~dec_err).
  - While HMASTLOCKM = 1 in DPHASE, req_port[dsel] stays asserted.
- Accept: acc = gnt_port[k] & HREADYM[k] for the requested k.
- FSM states: IDLE, HOLD, DPHASE, ERR1, ERR2.
  - IDLE/DPHASE on vld:
    - dec_err: go to ERR1.
    - acc: go to DPHASE with dsel = k.
    - otherwise: capture all address fields and k, hold_valid = 1, go to HOLD.
  - IDLE/DPHASE with no vld: DPHASE returns to IDLE once HREADYM[dsel] = 1.
  - HOLD: HREADYOUTS = 0, HRESPS = 0. On acc, clear hold_valid and go to DPHASE with dsel = held k. A held transfer is accepted with latency of at least 1 cycle after capture.
  - DPHASE: HREADYOUTS = HREADYM[dsel], HRESPS = HRESPM[dsel].
  - ERR1: HREADYOUTS = 0, HRESPS = 1.
  - ERR2: HREADYOUTS = 1, HRESPS = 1.
  - ERR2 then goes to IDLE, or handles a new vld exactly as IDLE does.
- Master data phase vs new address: in DPHASE, the master's HREADYS = 1 completes the data phase and may carry a new vld in the same cycle. The new transfer is decoded and accepted or held in that same cycle.
- ERROR from an output: the master may drive IDLE after it. No special handling; normal decode continues.
- HSELS = 0 with hold_valid: ignored. The held transfer is always completed.
- Reset mid-HOLD or mid-DPHASE: the held transfer is discarded and all state returns to reset values on the next edge.

Decomposition:
- Shared package holds:
  - HTRANS encodings TRN_IDLE/BUSY/NONSEQ/SEQ
  - HBURST encodings BUR_*
  - FSM state encoding (3-bit: IDLE, HOLD, DPHASE, ERR1, ERR2)
  - region decode function
- One natural sub-module: p_beid_interconnect_f0_ahb_mtx_decodeS. It is combinational (HADDRS, CONNECT, BASE/MASK to one-hot dec and dec_err) and is reused by every input port.

Test Plan:
- Live grant: gnt_port = 4'b0010, HREADYM = 4'b1111, NONSEQ to 32'h2000_0010 -> req_port = 4'b0010 in the same cycle; next cycle DPHASE, HREADYOUTS follows HREADYM[1]; no hold.
- Held transfer: gnt_port = 0, NONSEQ write to 32'h4000_0004 -> HOLD, HREADYOUTS = 0, req_port = 4'b0100, HADDRM = 32'h4000_0004 held stable. Raise gnt_port[2] after 3 cycles -> DPHASE next cycle, HREADYOUTS = 1.
- Unmapped: CONNECT = 4'b0111, NONSEQ to 32'h6000_0000 -> req_port = 0; cycle 1 HREADYOUTS = 0 / HRESPS = 1; cycle 2 HREADYOUTS = 1 / HRESPS = 1; then IDLE.
- Back-to-back: DPHASE on output 0 completes with a new NONSEQ to output 3 in the same cycle, gnt_port[3] = 0 -> captured in hold; req_port = 4'b1000 the next cycle, no lost beat.
- Wait states: in DPHASE, HREADYM[dsel] = 0 for 2 cycles -> HREADYOUTS = 0 for exactly 2 cycles; HRESPM error is forwarded on HRESPS.
- Reset in HOLD: assert HRESET for 1 cycle -> next edge hold_valid = 0, req_port = 0, HREADYOUTS = 1, HTRANSM = IDLE.
